// File: rtl/ucie_vc_adapter.sv
// ucie_vc_adapter: multi-VC UCIe rx parser with per-VC command FIFOs and a
// round-robin command arbiter, plus a two-beat PE response framer on tx.
// Ports: clk, rst_n; rx_valid/rx_ready/rx_data/rx_vc inbound link;
// cmd_valid/cmd_ready/cmd_type/cmd_addr_a/cmd_addr_b/cmd_trans_id/cmd_vc;
// res_valid/res_ready/res_data/res_trans_id; tx_valid/tx_ready/tx_data/
// tx_last outbound link; err_count saturating malformed-packet count.
// Optional macro UCIE_VC_ERR_RESP_EN: one-slot error response {EE,00,tid}.

module ucie_vc_adapter #(
  parameter int DATA_W      = 32,
  parameter int NUM_VC      = 2,
  parameter int CMD_DEPTH   = 8,
  parameter int RESP_DEPTH  = 8,
  parameter int MAX_PAYLOAD = 4,
  localparam int VCW = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic [DATA_W-1:0] rx_data,
  input  logic [VCW-1:0]    rx_vc,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [1:0]        cmd_type,
  output logic [DATA_W-1:0] cmd_addr_a,
  output logic [DATA_W-1:0] cmd_addr_b,
  output logic [15:0]       cmd_trans_id,
  output logic [VCW-1:0]    cmd_vc,
  input  logic              res_valid,
  output logic              res_ready,
  input  logic [DATA_W-1:0] res_data,
  input  logic [15:0]       res_trans_id,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_last,
  output logic [7:0]        err_count
);

  localparam int CAW = $clog2(CMD_DEPTH);
  localparam int RAW = $clog2(RESP_DEPTH);

  typedef struct packed {
    logic [1:0]        typ;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [15:0]       tid;
  } cmd_t;

  typedef struct packed {
    logic [15:0]       tid;
    logic [DATA_W-1:0] d;
  } res_t;

  typedef enum logic [1:0] {RX_HDR, RX_PAY, RX_DRAIN} rx_t;
`ifdef UCIE_VC_ERR_RESP_EN
  typedef enum logic [1:0] {TX_IDLE, TX_HDR, TX_DATA, TX_ERR} tx_t;
`else
  typedef enum logic [1:0] {TX_IDLE, TX_HDR, TX_DATA} tx_t;
`endif

  rx_t rx_st, rx_nx;
  tx_t tx_st, tx_nx;

  // Holds ready low for the first cycle out of reset as well.
  logic alive;

  logic [7:0]        len, bcnt;
  logic [1:0]        cur_type;
  logic [15:0]       cur_tid;
  logic [VCW-1:0]    cur_vc;
  logic [DATA_W-1:0] addr_a, addr_b;

  logic [7:0] h_type, h_len;
  logic       vc_ok, hdr_full, legal;
  logic       hdr_acc, beat_acc, last_beat, push, err_ev;
  cmd_t       pe;

  cmd_t             cmem [NUM_VC][CMD_DEPTH];
  logic [CAW:0]     cwp [NUM_VC];
  logic [CAW:0]     crp [NUM_VC];
  logic [NUM_VC-1:0] c_empty, c_full;

  logic [VCW-1:0] ptr, lock_vc, rr_vc, grant;
  logic           locked, rr_found, pop;
  int             k;
  cmd_t           head;

  res_t         rmem [RESP_DEPTH];
  logic [RAW:0] rwp, rrp;
  logic         r_empty, r_full, res_push, r_pop;
  res_t         rhead;

  assign h_type = rx_data[31:24];
  assign h_len  = rx_data[23:16];
  assign vc_ok  = int'(rx_vc) < NUM_VC;

  always_comb begin
    for (int v = 0; v < NUM_VC; v++) begin
      c_empty[v] = cwp[v] == crp[v];
      c_full[v]  = (cwp[v] - crp[v]) == (CAW+1)'(CMD_DEPTH);
    end
  end

  assign hdr_full = vc_ok ? c_full[rx_vc] : 1'b0;
  assign legal = vc_ok && (h_type == 8'h01 || h_type == 8'h02) &&
                 h_len != 8'd0 && h_len <= 8'(MAX_PAYLOAD);

  assign hdr_acc   = rx_st == RX_HDR && rx_valid && rx_ready;
  assign beat_acc  = rx_st != RX_HDR && rx_valid && rx_ready;
  assign last_beat = beat_acc && bcnt == len - 8'd1;
  assign push      = rx_st == RX_PAY && last_beat;
  assign err_ev    = (hdr_acc && !legal && h_len == 8'd0) ||
                     (rx_st == RX_DRAIN && last_beat);

  always_comb begin
    pe.typ = cur_type;
    pe.a   = (bcnt == 8'd0) ? rx_data : addr_a;
    pe.b   = (bcnt == 8'd1) ? rx_data : addr_b;
    pe.tid = cur_tid;
  end

  always_comb begin
    rx_nx    = rx_st;
    rx_ready = alive;
    unique case (rx_st)
      RX_HDR: begin
        rx_ready = alive && !hdr_full;
        if (hdr_acc && h_len != 8'd0)
          rx_nx = legal ? RX_PAY : RX_DRAIN;
      end
      default: if (last_beat) rx_nx = RX_HDR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alive    <= 1'b0;
      rx_st    <= RX_HDR;
      len      <= '0;
      bcnt     <= '0;
      cur_type <= '0;
      cur_tid  <= '0;
      cur_vc   <= '0;
      addr_a   <= '0;
      addr_b   <= '0;
    end else begin
      alive <= 1'b1;
      rx_st <= rx_nx;
      if (hdr_acc) begin
        len      <= h_len;
        bcnt     <= '0;
        cur_type <= h_type[1:0];
        cur_tid  <= rx_data[15:0];
        cur_vc   <= rx_vc;
        addr_a   <= '0;
        addr_b   <= '0;
      end else if (beat_acc) begin
        bcnt <= bcnt + 8'd1;
        if (rx_st == RX_PAY && bcnt == 8'd0) addr_a <= rx_data;
        if (rx_st == RX_PAY && bcnt == 8'd1) addr_b <= rx_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) cmem[cur_vc][cwp[cur_vc][CAW-1:0]] <= pe;
  end

  // Round-robin search starting at the VC after the last grant.
  always_comb begin
    rr_found = 1'b0;
    rr_vc    = '0;
    k        = 0;
    for (int i = 0; i < NUM_VC; i++) begin
      k = (int'(ptr) + i) % NUM_VC;
      if (!rr_found && !c_empty[k]) begin
        rr_found = 1'b1;
        rr_vc    = VCW'(k);
      end
    end
  end

  assign grant     = locked ? lock_vc : rr_vc;
  assign cmd_valid = locked || rr_found;
  assign pop       = cmd_valid && cmd_ready;
  assign head      = cmem[grant][crp[grant][CAW-1:0]];

  assign cmd_type     = cmd_valid ? head.typ : '0;
  assign cmd_addr_a   = cmd_valid ? head.a   : '0;
  assign cmd_addr_b   = cmd_valid ? head.b   : '0;
  assign cmd_trans_id = cmd_valid ? head.tid : '0;
  assign cmd_vc       = cmd_valid ? grant    : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int v = 0; v < NUM_VC; v++) begin
        cwp[v] <= '0;
        crp[v] <= '0;
      end
      ptr     <= '0;
      locked  <= 1'b0;
      lock_vc <= '0;
    end else begin
      if (push) cwp[cur_vc] <= cwp[cur_vc] + 1'b1;
      if (pop) begin
        crp[grant] <= crp[grant] + 1'b1;
        ptr        <= (int'(grant) == NUM_VC - 1) ? '0 : grant + 1'b1;
        locked     <= 1'b0;
      end else if (cmd_valid) begin
        locked  <= 1'b1;
        lock_vc <= grant;
      end
    end
  end

  assign r_empty   = rwp == rrp;
  assign r_full    = (rwp - rrp) == (RAW+1)'(RESP_DEPTH);
  assign res_ready = alive && !r_full;
  assign res_push  = res_valid && res_ready;
  assign r_pop     = tx_st == TX_DATA && tx_ready;
  assign rhead     = rmem[rrp[RAW-1:0]];

  always_ff @(posedge clk) begin
    if (res_push) rmem[rwp[RAW-1:0]] <= '{tid: res_trans_id, d: res_data};
  end

`ifdef UCIE_VC_ERR_RESP_EN
  logic        err_pend;
  logic [15:0] err_tid;
  logic [15:0] err_tid_in;

  assign err_tid_in = (rx_st == RX_HDR) ? rx_data[15:0] : cur_tid;

  // Releasing the slot wins over a same-cycle error; that error is only counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_pend <= 1'b0;
      err_tid  <= '0;
    end else if (tx_st == TX_ERR && tx_ready) begin
      err_pend <= 1'b0;
    end else if (err_ev && !err_pend) begin
      err_pend <= 1'b1;
      err_tid  <= err_tid_in;
    end
  end
`endif

  always_comb begin
    tx_nx    = tx_st;
    tx_valid = 1'b0;
    tx_last  = 1'b0;
    tx_data  = '0;
    unique case (tx_st)
      TX_IDLE: begin
`ifdef UCIE_VC_ERR_RESP_EN
        if (err_pend) tx_nx = TX_ERR; else
`endif
        if (!r_empty || res_push) tx_nx = TX_HDR;
      end
      TX_HDR: begin
        tx_valid = 1'b1;
        tx_data  = DATA_W'({8'h80, 8'h01, rhead.tid});
        if (tx_ready) tx_nx = TX_DATA;
      end
      TX_DATA: begin
        tx_valid = 1'b1;
        tx_last  = 1'b1;
        tx_data  = rhead.d;
        if (tx_ready) tx_nx = TX_IDLE;
      end
`ifdef UCIE_VC_ERR_RESP_EN
      TX_ERR: begin
        tx_valid = 1'b1;
        tx_last  = 1'b1;
        tx_data  = DATA_W'({8'hEE, 8'h00, err_tid});
        if (tx_ready) tx_nx = TX_IDLE;
      end
`endif
      default: tx_nx = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_st     <= TX_IDLE;
      rwp       <= '0;
      rrp       <= '0;
      err_count <= '0;
    end else begin
      tx_st <= tx_nx;
      if (res_push) rwp <= rwp + 1'b1;
      if (r_pop) rrp <= rrp + 1'b1;
      if (err_ev && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_ucie_vc_adapter.sv
// tb_ucie_vc_adapter: directed + randomized self-checking bench for
// ucie_vc_adapter, per-VC queue model for commands, beat queue for tx.

module tb_ucie_vc_adapter;

  typedef struct packed {
    logic        vc;
    logic [1:0]  typ;
    logic [31:0] a;
    logic [31:0] b;
    logic [15:0] tid;
  } cmd_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_valid = 1'b0, rx_ready;
  logic [31:0] rx_data = '0;
  logic        rx_vc = 1'b0;
  logic        cmd_valid, cmd_ready = 1'b0;
  logic [1:0]  cmd_type;
  logic [31:0] cmd_addr_a, cmd_addr_b;
  logic [15:0] cmd_trans_id;
  logic        cmd_vc;
  logic        res_valid = 1'b0, res_ready;
  logic [31:0] res_data = '0;
  logic [15:0] res_trans_id = '0;
  logic        tx_valid, tx_ready = 1'b0;
  logic [31:0] tx_data;
  logic        tx_last;
  logic [7:0]  err_count;

  int n_cmp = 0;
  int n_bad = 0;

  logic cr_mode = 1'b0, cr_val = 1'b0;
  logic tr_mode = 1'b0, tr_val = 1'b1;

  cmd_t        got_q[$];
  cmd_t        exp0[$];
  cmd_t        exp1[$];
  logic [32:0] tx_q[$];
  logic [32:0] tx_exp[$];
  logic [31:0] err_q[$];
  int          stall_bad = 0;
  int          err_exp = 0;

  always #5 clk = ~clk;

  ucie_vc_adapter dut (
    .clk(clk), .rst_n(rst_n),
    .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_data(rx_data), .rx_vc(rx_vc),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_type(cmd_type), .cmd_addr_a(cmd_addr_a),
    .cmd_addr_b(cmd_addr_b), .cmd_trans_id(cmd_trans_id),
    .cmd_vc(cmd_vc),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_trans_id(res_trans_id),
    .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_data(tx_data), .tx_last(tx_last),
    .err_count(err_count)
  );

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Ready drivers: fixed value or random, updated just after each negedge.
  initial forever begin
    @(negedge clk);
    #1;
    cmd_ready = cr_mode ? 1'($urandom) : cr_val;
    tx_ready  = tr_mode ? 1'($urandom) : tr_val;
  end

  // Monitor: record handshakes and check tx stability while stalled.
  logic        prev_stall = 1'b0;
  logic [31:0] pd;
  logic        pl;
  initial forever begin
    @(negedge clk);
    #2;
    if (!rst_n) prev_stall = 1'b0;
    else begin
      if (prev_stall && (tx_valid !== 1'b1 || tx_data !== pd || tx_last !== pl))
        stall_bad++;
      if (cmd_valid && cmd_ready)
        got_q.push_back('{vc: cmd_vc, typ: cmd_type, a: cmd_addr_a,
                          b: cmd_addr_b, tid: cmd_trans_id});
      if (tx_valid && tx_ready) begin
        if (tx_data[31:24] == 8'hEE) err_q.push_back(tx_data);
        else tx_q.push_back({tx_last, tx_data});
      end
      prev_stall = tx_valid && !tx_ready;
      pd = tx_data;
      pl = tx_last;
    end
  end

  task automatic rx_beat(input logic [31:0] d, input logic vc);
    logic ok = 1'b0;
    rx_valid = 1'b1;
    rx_data  = d;
    rx_vc    = vc;
    for (int i = 0; i < 300 && !ok; i++) begin
      #1;
      ok = rx_ready;
      @(posedge clk);
      @(negedge clk);
    end
    rx_valid = 1'b0;
    chk("rx_accept", ok, 1);
  endtask

  task automatic send_pkt(input logic [7:0] typ, input logic [7:0] len,
                          input logic [15:0] tid, input logic vc,
                          output logic [31:0] a, output logic [31:0] b);
    logic [31:0] w;
    a = '0;
    b = '0;
    rx_beat({typ, len, tid}, vc);
    for (int i = 0; i < int'(len); i++) begin
      w = $urandom;
      if (i == 0) a = w;
      if (i == 1) b = w;
      rx_beat(w, vc);
    end
  endtask

  task automatic res_send(input logic [31:0] d, input logic [15:0] tid);
    logic ok = 1'b0;
    res_valid    = 1'b1;
    res_data     = d;
    res_trans_id = tid;
    for (int i = 0; i < 300 && !ok; i++) begin
      #1;
      ok = res_ready;
      @(posedge clk);
      @(negedge clk);
    end
    res_valid = 1'b0;
    chk("res_accept", ok, 1);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [31:0] a, b, d;
    logic [15:0] t;
    logic [7:0]  typ, len;
    logic        vc;
    int          r, lim;
    cmd_t        e;

    // Reset values.
    wait_cyc(2);
    #3;
    chk("reset_rx_ready", rx_ready, 0);
    chk("reset_cmd_valid", cmd_valid, 0);
    chk("reset_res_ready", res_ready, 0);
    chk("reset_tx", {tx_valid, tx_last, tx_data}, 0);
    chk("reset_cmd_fields", {cmd_type, cmd_addr_a, cmd_addr_b,
                             cmd_trans_id, cmd_vc}, 0);
    chk("reset_err", err_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_cyc(3);

    // Round robin from VC0 over two loaded VCs.
    cr_val = 1'b0;
    for (int i = 0; i < 3; i++) send_pkt(8'h01, 8'd1, 16'(i), 1'b0, a, b);
    for (int i = 0; i < 3; i++) send_pkt(8'h01, 8'd1, 16'(i), 1'b1, a, b);
    got_q.delete();
    cr_val = 1'b1;
    wait_cyc(12);
    cr_val = 1'b0;
    chk("rr_count", got_q.size(), 6);
    for (int i = 0; i < 6; i++) chk("rr_vc_order", got_q[i].vc, i % 2);

    // Basic packet with command latency.
    wait_cyc(2);
    got_q.delete();
    rx_beat(32'h0102_0007, 1'b0);
    rx_beat(32'h100, 1'b0);
    #3;
    chk("basic_not_early", cmd_valid, 0);
    rx_beat(32'h200, 1'b0);
    #3;
    chk("basic_valid", cmd_valid, 1);
    chk("basic_fields", {cmd_type, cmd_addr_a, cmd_addr_b, cmd_trans_id,
                         cmd_vc}, {2'd1, 32'h100, 32'h200, 16'd7, 1'b0});
    cr_val = 1'b1;
    wait_cyc(3);
    cr_val = 1'b0;
    chk("basic_count", got_q.size(), 1);

    // Fill VC1, then stall the next VC1 header until one pop.
    wait_cyc(2);
    got_q.delete();
    exp1.delete();
    for (int i = 0; i < 8; i++) begin
      send_pkt(8'h02, 8'd2, 16'(16'h100 + i), 1'b1, a, b);
      exp1.push_back('{vc: 1'b1, typ: 2'd2, a: a, b: b,
                       tid: 16'(16'h100 + i)});
    end
    rx_valid = 1'b1;
    rx_data  = 32'h0102_0108;
    rx_vc    = 1'b1;
    r = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (rx_ready) r = 1;
      @(negedge clk);
    end
    chk("full_stall", r, 0);
    cr_val = 1'b1;
    @(negedge clk);
    cr_val = 1'b0;
    #2;
    chk("full_release", rx_ready, 1);
    send_pkt(8'h01, 8'd2, 16'h0108, 1'b1, a, b);
    exp1.push_back('{vc: 1'b1, typ: 2'd1, a: a, b: b, tid: 16'h0108});
    cr_val = 1'b1;
    for (int i = 0; i < 100 && got_q.size() < 9; i++) @(negedge clk);
    chk("full_count", got_q.size(), 9);
    for (int i = 0; i < 9; i++) chk("full_order", got_q[i], exp1[i]);
    exp1.delete();

    // Malformed packet is drained.
    got_q.delete();
    err_q.delete();
    rx_beat(32'h0503_0009, 1'b0);
    for (int i = 0; i < 3; i++) rx_beat($urandom, 1'b0);
    err_exp = 1;
    wait_cyc(10);
    chk("drain_no_cmd", got_q.size(), 0);
    chk("drain_err", err_count, err_exp);
`ifdef UCIE_VC_ERR_RESP_EN
    chk("err_resp_count", err_q.size(), 1);
    chk("err_resp_word", err_q[0], 32'hEE00_0009);
`endif

    // Response framing with tx_ready toggling.
    tx_q.delete();
    stall_bad = 0;
    tr_mode = 1'b1;
    res_send(32'hDEAD, 16'h42);
    #3;
    chk("tx_latency", {tx_valid, tx_last, tx_data}, {2'b10, 32'h8001_0042});
    for (int i = 0; i < 100 && tx_q.size() < 2; i++) @(negedge clk);
    chk("tx_count", tx_q.size(), 2);
    chk("tx_hdr", tx_q[0], {1'b0, 32'h8001_0042});
    chk("tx_data", tx_q[1], {1'b1, 32'h0000_DEAD});
    chk("tx_stable", stall_bad, 0);

    // Randomized mix against queue model.
    got_q.delete();
    tx_q.delete();
    tx_exp.delete();
    exp0.delete();
    cr_mode = 1'b1;
    for (int p = 0; p < 40; p++) begin
      vc = 1'($urandom);
      t  = 16'($urandom);
      r  = $urandom_range(0, 9);
      if (r < 7) begin
        typ = 8'($urandom_range(1, 2));
        len = 8'($urandom_range(1, 4));
      end else if (r == 7) begin
        typ = 8'h00;
        len = 8'($urandom_range(0, 3));
      end else if (r == 8) begin
        typ = 8'h01;
        len = 8'($urandom_range(5, 6));
      end else begin
        typ = 8'h02;
        len = 8'd0;
      end
      send_pkt(typ, len, t, vc, a, b);
      if (r < 7) begin
        e = '{vc: vc, typ: typ[1:0], a: a, b: b, tid: t};
        if (vc) exp1.push_back(e);
        else exp0.push_back(e);
      end else begin
        err_exp = (err_exp < 255) ? err_exp + 1 : 255;
      end
      if ($urandom_range(0, 2) == 0) begin
        d = $urandom & 32'h00FF_FFFF;
        t = 16'($urandom);
        res_send(d, t);
        tx_exp.push_back({1'b0, 16'h8001, t});
        tx_exp.push_back({1'b1, d});
      end
    end
    cr_mode = 1'b0;
    cr_val  = 1'b1;
    tr_mode = 1'b0;
    lim = exp0.size() + exp1.size();
    for (int i = 0; i < 500 && (got_q.size() < lim ||
         tx_q.size() < tx_exp.size()); i++) @(negedge clk);
    chk("rand_cmd_count", got_q.size(), lim);
    foreach (got_q[i]) begin
      if (got_q[i].vc) begin
        if (exp1.size() == 0) chk("rand_extra_vc1", exp1.size(), 1);
        else chk("rand_cmd_vc1", got_q[i], exp1.pop_front());
      end else begin
        if (exp0.size() == 0) chk("rand_extra_vc0", exp0.size(), 1);
        else chk("rand_cmd_vc0", got_q[i], exp0.pop_front());
      end
    end
    chk("rand_left", exp0.size() + exp1.size(), 0);
    chk("rand_err", err_count, err_exp);
    chk("rand_tx_count", tx_q.size(), tx_exp.size());
    foreach (tx_exp[i]) chk("rand_tx_beat", tx_q[i], tx_exp[i]);

    // Error counter saturation.
    for (int i = 0; i < 260; i++) begin
      rx_beat(32'h0000_0000, 1'b0);
      err_exp = (err_exp < 255) ? err_exp + 1 : 255;
    end
    wait_cyc(2);
    chk("err_saturate", err_count, err_exp);
    wait_cyc(10);

    // Reset in the middle of a packet.
    cr_val = 1'b0;
    got_q.delete();
    rx_beat(32'h0102_000A, 1'b0);
    rx_beat(32'h111, 1'b0);
    rst_n = 1'b0;
    #3;
    chk("midrst_ready", {rx_ready, res_ready}, 0);
    chk("midrst_cmd", {cmd_valid, cmd_type, cmd_addr_a, cmd_addr_b,
                       cmd_trans_id, cmd_vc}, 0);
    chk("midrst_tx", {tx_valid, tx_last, tx_data}, 0);
    chk("midrst_err", err_count, 0);
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(5);
    chk("midrst_no_cmd", {cmd_valid, 32'(got_q.size())}, 0);
    rx_beat(32'h0201_000B, 1'b0);
    rx_beat(32'h333, 1'b0);
    #3;
    chk("fresh_fields", {cmd_valid, cmd_type, cmd_addr_a, cmd_addr_b,
                         cmd_trans_id, cmd_vc},
        {1'b1, 2'd2, 32'h333, 32'h0, 16'h000B, 1'b0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
